// File: rtl/lemonpc_pkg.sv
// Shared types and constants for the writeback path: result-source encoding,
// ALU starvation limit and the fixed-priority-with-starvation arbitration rule.
package lemonpc_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  // ALU may lose this many back-to-back contested arbitrations before it is forced through
  localparam int unsigned STARVE_LIMIT = 2;
  localparam int unsigned LOSS_CNT_W   = $clog2(STARVE_LIMIT + 1);

  function automatic wb_src_e wb_arbitrate(input logic alu_v, input logic lsu_v,
                                           input logic alu_starved);
    wb_src_e src;
    if (alu_v && (!lsu_v || alu_starved)) begin
      src = SRC_ALU;
    end else if (lsu_v) begin
      src = SRC_LSU;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
// A set and a clear aimed at the same register on one edge leaves it busy.
module wb_scoreboard
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic [ADDR_WIDTH-1:0] issue_idx,
  output logic                  issue_busy,
  input  logic [ADDR_WIDTH-1:0] rs1_idx,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_idx,
  output logic                  rs2_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit    = set_en && (set_idx == ADDR_WIDTH'(gi));
        assign clr_hit    = clr_en && (clr_idx == ADDR_WIDTH'(gi));
        assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign issue_busy = busy_q[issue_idx];
  assign rs1_busy   = busy_q[rs1_idx];
  assign rs2_busy   = busy_q[rs2_idx];

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges ALU/LSU results into one registered register-file write per
// cycle and tracks pending destinations. Define WB_BYPASS_EN to add operand forwarding ports.
module writeback_unit
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
`ifdef WB_BYPASS_EN
  ,
  output logic                  rs1_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data
`endif
);

  wb_src_e               grant;
  logic                  alu_starved;
  logic [LOSS_CNT_W-1:0] loss_q;
  logic [LOSS_CNT_W-1:0] loss_d;
  logic [ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  rf_wen_q;
  logic                  rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic [ADDR_WIDTH-1:0] rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_data_q;
  logic [DATA_WIDTH-1:0] rf_data_d;
  logic                  issue_busy;
  logic                  issue_set;
  logic                  rs1_sb_busy;
  logic                  rs2_sb_busy;

  assign alu_starved = (loss_q >= LOSS_CNT_W'(STARVE_LIMIT));
  assign grant       = wb_arbitrate(alu_valid, lsu_valid, alu_starved);
  assign alu_ready   = (grant == SRC_ALU);
  assign lsu_ready   = (grant == SRC_LSU);

  // Any ALU win ends its losing streak; only contested LSU wins extend it
  always_comb begin
    acc_rd   = '0;
    acc_data = '0;
    loss_d   = loss_q;
    unique case (grant)
      SRC_ALU: begin
        acc_rd   = alu_rd;
        acc_data = alu_data;
        loss_d   = '0;
      end
      SRC_LSU: begin
        acc_rd   = lsu_rd;
        acc_data = lsu_data;
        if (alu_valid) begin
          loss_d = loss_q + LOSS_CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Results for x0 are consumed but never written
  always_comb begin
    rf_wen_d  = (grant != SRC_NONE) && (acc_rd != '0);
    rf_rd_d   = rf_wen_d ? acc_rd : rf_rd_q;
    rf_data_d = rf_wen_d ? acc_data : rf_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q    <= '0;
      rf_wen_q  <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      loss_q    <= loss_d;
      rf_wen_q  <= rf_wen_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_rd   = rf_rd_q;
  assign rf_data = rf_data_q;

  assign issue_ready = !issue_busy;
  assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);

  wb_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (issue_set),
    .set_idx    (issue_rd),
    .clr_en     (rf_wen_q),
    .clr_idx    (rf_rd_q),
    .issue_idx  (issue_rd),
    .issue_busy (issue_busy),
    .rs1_idx    (rs1),
    .rs1_busy   (rs1_sb_busy),
    .rs2_idx    (rs2),
    .rs2_busy   (rs2_sb_busy)
  );

`ifdef WB_BYPASS_EN
  // The value being written this cycle is readable from the forward path right away
  assign rs1_fwd_valid = rf_wen_q && (rf_rd_q == rs1) && (rs1 != '0);
  assign rs2_fwd_valid = rf_wen_q && (rf_rd_q == rs2) && (rs2 != '0);
  assign rs1_fwd_data  = rf_data_q;
  assign rs2_fwd_data  = rf_data_q;
  assign rs1_busy      = rs1_sb_busy && !rs1_fwd_valid;
  assign rs2_busy      = rs2_sb_busy && !rs2_fwd_valid;
`else
  assign rs1_busy = rs1_sb_busy;
  assign rs2_busy = rs2_sb_busy;
`endif

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, result data width.
REQ-003 SHALL have ports: clk  in  1  clock, all state on posedge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: issue_valid  in  1  decode requests pending write; issue_rd  in  ADDR_WIDTH  destination; issue_ready  out  1  request accepted.
REQ-005 SHALL have ports: alu_valid  in  1; alu_ready  out  1; alu_rd  in  ADDR_WIDTH; alu_data  in  DATA_WIDTH.
REQ-006 SHALL have ports: lsu_valid  in  1; lsu_ready  out  1; lsu_rd  in  ADDR_WIDTH; lsu_data  in  DATA_WIDTH.
REQ-007 SHALL have ports: rf_wen  out  1; rf_rd  out  ADDR_WIDTH; rf_data  out  DATA_WIDTH; drive register file write port.
REQ-008 SHALL have ports: rs1, rs2  in  ADDR_WIDTH  hazard query; rs1_busy, rs2_busy  out  1  operand not yet readable.

Function
REQ-009 SHALL commit at most one result per cycle; a source is accepted when its valid and ready are both high.
REQ-010 SHALL grant LSU when only LSU valid, ALU when only ALU valid; when both valid, LSU wins unless ALU has lost 2 consecutive arbitrations, then ALU wins and loss counter clears.
REQ-011 SHALL derive alu_ready/lsu_ready combinationally from grant; ready of the non-valid source is 0.
REQ-012 SHALL register accepted result: accept in cycle N -> rf_wen=1, rf_rd, rf_data in cycle N+1; rf_wen=0 in cycles with no accept.
REQ-013 SHALL accept results with rd=0 (ready per arbitration) but keep rf_wen=0 for them.
REQ-014 SHALL keep busy[2^ADDR_WIDTH] scoreboard; bit 0 hardwired 0.
REQ-015 SHALL drive issue_ready = !busy[issue_rd]; issue_valid&&issue_ready&&issue_rd!=0 sets busy[issue_rd] at next edge.
REQ-016 SHALL clear busy[rf_rd] at the edge ending an rf_wen=1 cycle (data then resident in register file).
REQ-017 SHALL let set win over clear when both target the same bit on one edge.
REQ-018 SHALL drive rsX_busy = busy[rsX] combinationally (X=1,2).
REQ-019 SHALL write results whose rd is not busy normally, without scoreboard change.

Reset
REQ-020 SHALL on rst_n=0 clear busy, loss counter, rf_wen, rf_rd, rf_data to 0 immediately.
REQ-021 SHALL discard any result accepted in the cycle reset asserts; first write possible one cycle after rst_n rises.

Configuration
REQ-022 SHALL support macro WB_BYPASS_EN.
REQ-023 With WB_BYPASS_EN: SHALL add outputs rs1_fwd_valid, rs2_fwd_valid (1) and rs1_fwd_data, rs2_fwd_data (DATA_WIDTH); rsX_fwd_valid=rf_wen&&rf_rd==rsX&&rsX!=0, rsX_fwd_data=rf_data, and rsX_busy forced 0 when rsX_fwd_valid.
REQ-024 Without WB_BYPASS_EN: SHALL omit those ports; rsX_busy per REQ-018 only.

Structure
REQ-025 SHALL place result-source enum (SRC_NONE, SRC_ALU, SRC_LSU) and starvation limit constant (2) in shared package lemonpc_pkg.
REQ-026 SHALL implement scoreboard as sub-module wb_scoreboard (set/clear/query ports); arbitration and output register stay in top.

Verification
REQ-027 Issue rd=5, ALU returns rd=5 data 0x1234 next cycle -> rf_wen=1, rf_rd=5, rf_data=0x1234 one cycle later; rs1=5 busy until the edge after that.
REQ-028 ALU and LSU valid 4 cycles straight (rd 1..4) -> grant order LSU, LSU, ALU, LSU.
REQ-029 LSU result rd=0 data 0xFFFF -> lsu_ready=1, rf_wen stays 0.
REQ-030 rd=7 busy, issue_valid rd=7 -> issue_ready=0; same edge as rf_rd=7 clear, new issue rd=7 next cycle -> busy[7]=1 afterwards.
REQ-031 With WB_BYPASS_EN, rf_wen write rd=3 data 0xABCD, rs2=3 -> rs2_fwd_valid=1, rs2_fwd_data=0xABCD, rs2_busy=0.
REQ-032 rst_n low mid-burst with busy rd 2,9 set -> rf_wen=0, rs1_busy=0 for rs1=2 and rs1=9 immediately.
